// File: rtl/csr_if.sv
// csr_if: commit-stage strobes, interrupt lines and CSR/redirect results
interface csr_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_IRQ = 3
);
    logic [NUM_IRQ-1:0] irq;
    logic               instr_valid, stall, ecall, uret, csrrw, csrrsi, csrrci;
    logic [WIDTH-1:0]   pc, rs1_data, csr_rdata, redirect_pc;
    logic [11:0]        csr_addr;
    logic [4:0]         zimm;
    logic               redirect, int_pending;
    modport master (
        output irq, instr_valid, stall, pc, ecall, uret, csrrw, csrrsi, csrrci,
               csr_addr, rs1_data, zimm,
        input  csr_rdata, redirect, redirect_pc, int_pending
    );
    modport slave (
        input  irq, instr_valid, stall, pc, ecall, uret, csrrw, csrrsi, csrrci,
               csr_addr, rs1_data, zimm,
        output csr_rdata, redirect, redirect_pc, int_pending
    );
endinterface

// File: rtl/csr_interrupt_unit.sv
// csr_interrupt_unit: user-mode CSRs, interrupt/ecall trap entry and uret redirect
// Define CSR_VECTORED_EN to make utvec[0] a vectored-interrupt mode bit.
module csr_interrupt_unit #(
    parameter int               WIDTH       = 32,
    parameter int               NUM_IRQ     = 3,
    parameter logic [WIDTH-1:0] UTVEC_RESET = '0
) (
    input logic  clk,
    input logic  rst,
    csr_if.slave bus
);
`ifdef CSR_VECTORED_EN
    localparam logic [WIDTH-1:0] TVEC_MASK = ~WIDTH'(2);
`else
    localparam logic [WIDTH-1:0] TVEC_MASK = ~WIDTH'(3);
`endif
    logic               uie_bit, upie, go, take, do_ecall, do_uret, do_write;
    logic [NUM_IRQ-1:0] uie, uip, irq_q, pend, clr;
    logic [WIDTH-1:0]   utvec, uepc, ucause, tvec_rd, uepc_rd, base, int_target, old, zext, wdata;
    logic [2:0]         idx;
    assign go       = bus.instr_valid & ~bus.stall & ~rst;
    assign pend     = uip & uie;
    assign take     = go & uie_bit & |pend;
    assign do_ecall = go & ~take & bus.ecall;
    assign do_uret  = go & ~take & bus.uret;
    assign do_write = go & ~take & (bus.csrrw | ((bus.csrrsi | bus.csrrci) & |bus.zimm));
    assign clr      = take ? NUM_IRQ'(1) << idx : '0;
    assign tvec_rd  = utvec & TVEC_MASK;
    assign uepc_rd  = {uepc[WIDTH-1:2], 2'b00};
    assign base     = {utvec[WIDTH-1:2], 2'b00};
    assign zext     = WIDTH'(bus.zimm);
`ifdef CSR_VECTORED_EN
    assign int_target = utvec[0] ? base + (WIDTH'(idx) << 2) : base;
`else
    assign int_target = base;
`endif
    // Lowest-index pending-and-enabled interrupt wins
    always_comb begin
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend[i]) idx = 3'(i);
    end
    always_comb begin
        old = '0;
        case (bus.csr_addr)
            12'h000: old = WIDTH'({upie, 3'b000, uie_bit});
            12'h004: old = WIDTH'(uie);
            12'h005: old = tvec_rd;
            12'h041: old = uepc_rd;
            12'h042: old = ucause;
            12'h044: old = WIDTH'(uip);
            default: old = '0;
        endcase
    end
    assign wdata           = bus.csrrw ? bus.rs1_data : bus.csrrsi ? old | zext : old & ~zext;
    assign bus.csr_rdata   = old;
    assign bus.redirect    = take | do_ecall | do_uret;
    assign bus.redirect_pc = take ? int_target : do_ecall ? base : do_uret ? uepc_rd : '0;
    assign bus.int_pending = |pend;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uie_bit <= 1'b0;
            upie    <= 1'b0;
            uie     <= '0;
            uip     <= '0;
            irq_q   <= '0;
            utvec   <= UTVEC_RESET;
            uepc    <= '0;
            ucause  <= '0;
        end else begin
            irq_q <= bus.irq;
            // A new edge on the same cycle as a take keeps the bit set
            uip   <= (uip & ~clr) | (bus.irq & ~irq_q);
            if (take | do_ecall) begin
                uepc    <= bus.pc;
                ucause  <= take ? {1'b1, (WIDTH-1)'(idx)} : WIDTH'(8);
                upie    <= uie_bit;
                uie_bit <= 1'b0;
            end else if (do_uret) begin
                uie_bit <= upie;
                upie    <= 1'b1;
            end else if (do_write) begin
                case (bus.csr_addr)
                    12'h000: begin
                        uie_bit <= wdata[0];
                        upie    <= wdata[4];
                    end
                    12'h004: uie    <= wdata[NUM_IRQ-1:0];
                    12'h005: utvec  <= wdata;
                    12'h041: uepc   <= wdata;
                    12'h042: ucause <= wdata;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_csr_interrupt_unit.sv
// tb_csr_interrupt_unit: scoreboard bench for CSR access, traps, uret and irq handling
module tb_csr_interrupt_unit;
    localparam int W = 32, N = 3;
    localparam int RD = 0, RE = 1, RPC = 2, IP = 3;
    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0, n_bad = 0;
    exp_t sb[$];
    csr_if #(.WIDTH(W), .NUM_IRQ(N)) bus ();
    csr_interrupt_unit #(.WIDTH(W), .NUM_IRQ(N), .UTVEC_RESET(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic push(input string tag, input int kind, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask
    task automatic step();
        exp_t        e;
        logic [31:0] got;
        #2;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            got = e.kind == RD ? bus.csr_rdata : e.kind == RE ? 32'(bus.redirect) :
                  e.kind == RPC ? bus.redirect_pc : 32'(bus.int_pending);
            chk(e.tag, got, e.val);
        end
        @(negedge clk);
    endtask
    task automatic idle();
        bus.instr_valid = 0; bus.stall = 0; bus.ecall = 0; bus.uret = 0;
        bus.csrrw = 0; bus.csrrsi = 0; bus.csrrci = 0;
        bus.pc = '0; bus.csr_addr = '0; bus.rs1_data = '0; bus.zimm = '0;
    endtask
    task automatic commit(input logic [31:0] pc_v);
        idle();
        bus.instr_valid = 1;
        bus.pc = pc_v;
    endtask
    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] v);
        idle();
        bus.csr_addr = a;
        push(tag, RD, v);
        step();
    endtask
    task automatic redir(input string tag, input logic r, input logic [31:0] t);
        push({tag, "_re"}, RE, 32'(r));
        if (r) push({tag, "_pc"}, RPC, t);
    endtask
    task automatic do_uret(input string tag, input logic [31:0] t);
        commit(32'h200);
        bus.uret = 1;
        redir(tag, 1, t);
        step();
    endtask
    initial begin
        bus.irq = '0;
        idle();
        @(negedge clk);
        commit(32'h10);
        bus.ecall = 1;
        push("rst_re", RE, 0); push("rst_pc", RPC, 0); push("rst_ip", IP, 0);
        step();
        rd("rst_utvec", 12'h005, 32'h0);
        rst = 0;
        commit(32'h0); bus.csrrw = 1; bus.csr_addr = 12'h005; bus.rs1_data = 32'h100;
        push("wr_utvec_old", RD, 0); redir("wr_utvec", 0, 0); step();
        commit(32'h4); bus.csrrsi = 1; bus.csr_addr = 12'h004; bus.zimm = 5'h7;
        push("wr_uie_old", RD, 0); step();
        commit(32'h8); bus.csrrsi = 1; bus.csr_addr = 12'h000; bus.zimm = 5'h1;
        push("wr_ustatus_old", RD, 0); step();
        rd("utvec", 12'h005, 32'h100);
        rd("uie", 12'h004, 32'h7);
        rd("ustatus", 12'h000, 32'h1);
        // single interrupt
        bus.irq = 3'b010; idle(); push("irq1_notyet", IP, 0); step();
        idle(); push("irq1_pend", IP, 1); step();
        commit(32'h40); redir("irq1_take", 1, 32'h100); step();
        rd("irq1_uepc", 12'h041, 32'h40);
        rd("irq1_ucause", 12'h042, 32'h8000_0001);
        rd("irq1_ustatus", 12'h000, 32'h10);
        rd("irq1_uip", 12'h044, 32'h0);
        bus.irq = 3'b000;
        do_uret("uret1", 32'h40);
        rd("uret1_ustatus", 12'h000, 32'h11);
        // simultaneous irq0/irq2: lowest index first
        bus.irq = 3'b101; idle(); step();
        commit(32'h50); redir("irq0_take", 1, 32'h100); step();
        rd("irq0_ucause", 12'h042, 32'h8000_0000);
        rd("irq0_uip", 12'h044, 32'h4);
        do_uret("uret2", 32'h50);
        commit(32'h60); redir("irq2_take", 1, 32'h100); step();
        rd("irq2_ucause", 12'h042, 32'h8000_0002);
        bus.irq = 3'b000;
        do_uret("uret3", 32'h60);
        // ecall with UIE=0
        commit(32'h20); bus.csrrci = 1; bus.csr_addr = 12'h000; bus.zimm = 5'h1;
        push("clr_uie_old", RD, 32'h11); step();
        commit(32'h24); bus.ecall = 1; redir("ecall", 1, 32'h100); step();
        rd("ecall_uepc", 12'h041, 32'h24);
        rd("ecall_ucause", 12'h042, 32'h8);
        rd("ecall_ustatus", 12'h000, 32'h0);
        do_uret("ecall_uret", 32'h24);
        rd("ecall_uret_ustatus", 12'h000, 32'h10);
        // interrupt beats a CSR write in commit
        commit(32'h28); bus.csrrsi = 1; bus.csr_addr = 12'h000; bus.zimm = 5'h1;
        push("set_uie_old", RD, 32'h10); step();
        bus.irq = 3'b010; idle(); step();
        commit(32'h70); bus.csrrw = 1; bus.csr_addr = 12'h004; bus.rs1_data = 32'h0;
        push("sup_old", RD, 32'h7); redir("sup_take", 1, 32'h100); step();
        rd("sup_uie", 12'h004, 32'h7);
        rd("sup_ucause", 12'h042, 32'h8000_0001);
        bus.irq = 3'b000;
        do_uret("uret4", 32'h70);
        // stall holds the interrupt off
        bus.irq = 3'b010; idle(); step();
        for (int i = 0; i < 2; i++) begin
            commit(32'h80); bus.stall = 1;
            redir("stall", 0, 0); push("stall_ip", IP, 1); step();
        end
        commit(32'h80); redir("unstall", 1, 32'h100); step();
        rd("unstall_uepc", 12'h041, 32'h80);
        do_uret("uret5", 32'h80);
        // vectored mode
        commit(32'h90); bus.csrrw = 1; bus.csr_addr = 12'h005; bus.rs1_data = 32'h101;
        push("vec_old", RD, 32'h100); step();
`ifdef CSR_VECTORED_EN
        rd("vec_utvec", 12'h005, 32'h101);
`else
        rd("vec_utvec", 12'h005, 32'h100);
`endif
        bus.irq = 3'b100; idle(); step();
        commit(32'h94);
`ifdef CSR_VECTORED_EN
        redir("vec_take", 1, 32'h108);
`else
        redir("vec_take", 1, 32'h100);
`endif
        step();
        // no-write and ignored writes
        commit(32'h98); bus.csrrsi = 1; bus.csr_addr = 12'h004;
        push("zimm0_old", RD, 32'h7); redir("zimm0", 0, 0); step();
        rd("zimm0_uie", 12'h004, 32'h7);
        commit(32'h9c); bus.csrrw = 1; bus.csr_addr = 12'h044; bus.rs1_data = 32'hff;
        push("uip_wr_old", RD, 32'h0); step();
        rd("uip_ro", 12'h044, 32'h0);
        rd("unknown", 12'h123, 32'h0);
        commit(32'ha0); bus.csrrw = 1; bus.csr_addr = 12'h041; bus.rs1_data = 32'h43;
        push("uepc_wr_old", RD, 32'h94); step();
        rd("uepc_mask", 12'h041, 32'h40);
        // reset mid-operation drops pending state
        bus.irq = 3'b001; idle(); step();
        idle(); push("pre_rst_ip", IP, 1); step();
        rst = 1; idle(); push("mid_rst_ip", IP, 0); step();
        rd("mid_rst_ustatus", 12'h000, 32'h0);
        bus.irq = 3'b000;
        rd("mid_rst_utvec", 12'h005, 32'h0);
        rst = 0;
        rd("post_rst_uip", 12'h044, 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
